// File: rtl/fa_chunk_seq.sv
// Multi-cycle WIDTH-bit adder: one CHUNK-bit ripple slice per clock, LSB chunk first.
// Optional signed-overflow output enabled by defining FA_CHUNK_SEQ_OVF_EN.

module fa_nbit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  // Ripple carry through every bit of the slice
  always_comb begin
    logic c;
    c = ci;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

module fa_chunk_seq #(
  parameter int WIDTH = 12,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             busy
`ifdef FA_CHUNK_SEQ_OVF_EN
  ,output logic            ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [CHUNK-1:0] sum_chunk;
  logic             chunk_co;
  logic             carry_into_msb;

  fa_nbit #(.WIDTH(CHUNK)) u_add (
    .a  (a_q[CHUNK-1:0]),
    .b  (b_q[CHUNK-1:0]),
    .ci (carry_q),
    .s  (sum_chunk),
    .co (chunk_co)
  );

  // On the last chunk the operand MSBs sit at slice bit CHUNK-1
  assign carry_into_msb = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ sum_chunk[CHUNK-1];

  // Next-state and datapath update for the sequencer
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int k = 0; k < NCHUNK; k++) begin
          if (cnt_q == CW'(k)) begin
            s_d[k*CHUNK +: CHUNK] = sum_chunk;
          end else begin
            s_d[k*CHUNK +: CHUNK] = s_q[k*CHUNK +: CHUNK];
          end
        end
        carry_d = chunk_co;
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        if (cnt_q == CW'(NCHUNK - 1)) begin
          co_d    = chunk_co;
          ovf_d   = carry_into_msb ^ chunk_co;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign s         = s_q;
  assign co        = co_q;

`ifdef FA_CHUNK_SEQ_OVF_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule
